alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable synchronised button samples required for press and release; board builds set 1000000.
REQ-002 The block SHALL have clk input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have rst input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have btn_exec input, 1 bit, the raw, unsynchronised execute pushbutton.
REQ-005 The block SHALL have sw_a input, 2 bits, the operand A switches.
REQ-006 The block SHALL have sw_b input, 2 bits, the operand B switches.
REQ-007 The block SHALL have sw_op input, 3 bits, the opcode switches.
REQ-008 The block SHALL have mux_out input, 2 bits, the result returned by the downstream 8:1 2-bit result multiplexer.
REQ-009 The block SHALL have op_a output, 2 bits, the latched operand A driven to the ALU function units.
REQ-010 The block SHALL have op_b output, 2 bits, the latched operand B driven to the ALU function units.
REQ-011 The block SHALL have sel output, 3 bits, the latched opcode driving the result multiplexer select.
REQ-012 The block SHALL have result output, 2 bits, the captured ALU result.
REQ-013 The block SHALL have result_valid output, 1 bit, high while result holds the outcome of the latest execute.
REQ-014 The block SHALL have busy output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-015 The block SHALL pass btn_exec through a 2-flop synchroniser; the output of that synchroniser is btn_s, and all FSM decisions SHALL use btn_s only.
REQ-016 The FSM SHALL have the states IDLE, DEBOUNCE, LATCH, SETTLE, CAPTURE and RELEASE, and an internal counter cnt wide enough to hold DEBOUNCE_CYCLES-1.
REQ-017 In IDLE, btn_s=1 SHALL cause a transition to DEBOUNCE with cnt<=0; otherwise the FSM SHALL stay in IDLE.
REQ-018 In DEBOUNCE, btn_s=0 SHALL cause a return to IDLE with no output change; btn_s=1 with cnt==DEBOUNCE_CYCLES-1 SHALL cause a transition to LATCH; otherwise cnt SHALL increment.
REQ-019 In LATCH, the block SHALL load op_a<=sw_a, op_b<=sw_b, sel<=sw_op and result_valid<=0, then go to SETTLE unconditionally.
REQ-020 SETTLE SHALL last exactly one cycle, allowing the combinational ALU and multiplexer path to settle, then go to CAPTURE.
REQ-021 In CAPTURE, the block SHALL load result<=mux_out and result_valid<=1, then go to RELEASE with cnt<=0.
REQ-022 In RELEASE, btn_s=1 SHALL reset cnt to 0; btn_s=0 with cnt==DEBOUNCE_CYCLES-1 SHALL cause a transition to IDLE; otherwise cnt SHALL increment. A held button SHALL never retrigger.
REQ-023 Latency: with btn_exec first sampled high at edge 1 and held, LATCH outputs SHALL update at edge N+4 and result_valid SHALL rise at edge N+6, where N=DEBOUNCE_CYCLES.
REQ-024 op_a, op_b and sel SHALL change only in LATCH; switch changes at any other time SHALL be ignored until the next execute.
REQ-025 result and result_valid SHALL hold their values through RELEASE and IDLE until the next LATCH.
REQ-026 busy SHALL be combinationally derived as (state != IDLE).
REQ-027 Unused state encodings SHALL return the FSM to IDLE on the next edge.

Reset
REQ-028 Asserting rst SHALL immediately force state=IDLE, cnt=0, the synchroniser flops=0, and op_a, op_b, sel, result, result_valid and busy all to 0, regardless of clock.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; after release, no capture SHALL occur until a fresh debounced press is seen.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Bench SHALL drive sw_a=2'b10, sw_b=2'b01, sw_op=3'b011 with a held press, model mux_out=sel-dependent value 2'b11 -> result=2'b11, result_valid=1 at edge 10, sel=3'b011.
REQ-031 Bench SHALL apply a 3-cycle glitch on btn_exec -> FSM returns to IDLE, no LATCH, result_valid unchanged.
REQ-032 Bench SHALL hold the button 50 cycles after capture, then toggle the switches -> exactly one capture, op_a/op_b/sel unchanged.
REQ-033 Bench SHALL bounce the button during RELEASE (low 2 cycles, high 1, low 4) -> FSM reaches IDLE only after 4 consecutive low samples.
REQ-034 Bench SHALL assert rst during SETTLE -> all outputs 0 immediately, state IDLE, no capture after release.
REQ-035 Bench SHALL perform two back-to-back executes with different opcodes -> result_valid drops at the second LATCH and rises again with the new result.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - debounced execute sequencer that latches ALU operands and captures the muxed result
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_exec,
    input  logic [1:0] sw_a,
    input  logic [1:0] sw_b,
    input  logic [2:0] sw_op,
    input  logic [1:0] mux_out,
    output logic [1:0] op_a,
    output logic [1:0] op_b,
    output logic [2:0] sel,
    output logic [1:0] result,
    output logic       result_valid,
    output logic       busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_LATCH    = 3'd2,
        S_SETTLE   = 3'd3,
        S_CAPTURE  = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sync1;
    logic          r_btn_s;
    logic [1:0]    r_op_a;
    logic [1:0]    r_op_b;
    logic [2:0]    r_sel;
    logic [1:0]    r_result;
    logic          r_result_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn_exec;
            r_btn_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_op_a         <= 2'b00;
            r_op_b         <= 2'b00;
            r_sel          <= 3'b000;
            r_result       <= 2'b00;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_btn_s) begin
                        r_state <= S_DEBOUNCE;
                        r_cnt   <= '0;
                    end
                end
                S_DEBOUNCE: begin
                    if (!r_btn_s) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LATCH: begin
                    r_op_a         <= sw_a;
                    r_op_b         <= sw_b;
                    r_sel          <= sw_op;
                    r_result_valid <= 1'b0;
                    r_state        <= S_SETTLE;
                end
                // One idle cycle so the external ALU/mux path sees the new operands.
                S_SETTLE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_result       <= mux_out;
                    r_result_valid <= 1'b1;
                    r_cnt          <= '0;
                    r_state        <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (r_btn_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign sel          = r_sel;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a modelled ALU/mux downstream
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_exec;
    logic [1:0] sw_a;
    logic [1:0] sw_b;
    logic [2:0] sw_op;
    logic [1:0] mux_out;
    logic [1:0] op_a;
    logic [1:0] op_b;
    logic [2:0] sel;
    logic [1:0] result;
    logic       result_valid;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_caps   = 0;
    logic prev_rv = 1'b0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_exec(btn_exec),
        .sw_a(sw_a), .sw_b(sw_b), .sw_op(sw_op), .mux_out(mux_out),
        .op_a(op_a), .op_b(op_b), .sel(sel),
        .result(result), .result_valid(result_valid), .busy(busy)
    );

    function automatic logic [1:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    assign mux_out = alu_model(op_a, op_b, sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Each rising edge of result_valid is one capture; it must match the oldest pending execute.
    always @(negedge clk) begin
        if (!rst && result_valid && !prev_rv) begin
            n_caps++;
            check("capture_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                logic [8:0] e;
                e = sb_q.pop_front();
                check("sb_result", result, e[8:7]);
                check("sb_op_a", op_a, e[6:5]);
                check("sb_op_b", op_b, e[4:3]);
                check("sb_sel", sel, e[2:0]);
            end
        end
        prev_rv = result_valid;
    end

    task automatic push_exp(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        sb_q.push_back({alu_model(a, b, op), a, b, op});
    endtask

    task automatic wait_caps(input int target);
        int k = 0;
        while (n_caps < target && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("capture_seen", n_caps, target);
    endtask

    task automatic release_btn();
        btn_exec = 1'b0;
        repeat (10) @(negedge clk);
        check("release_idle", busy, 0);
    endtask

    // Cycle-exact press: edge numbering starts at the first edge that samples the button high.
    task automatic press_exact(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                               input logic [2:0] prev_sel);
        @(negedge clk);
        sw_a = a; sw_b = b; sw_op = op; btn_exec = 1'b1;
        push_exp(a, b, op);
        repeat (7) @(negedge clk);
        check("e7_sel_held", sel, prev_sel);
        check("e7_busy", busy, 1);
        @(negedge clk);
        check("e8_op_a", op_a, a);
        check("e8_op_b", op_b, b);
        check("e8_sel", sel, op);
        check("e8_rv_low", result_valid, 0);
        @(negedge clk);
        check("e9_rv_low", result_valid, 0);
        @(negedge clk);
        check("e10_rv", result_valid, 1);
        check("e10_result", result, alu_model(a, b, op));
    endtask

    initial begin
        int caps0;
        rst = 1'b1; btn_exec = 1'b0; sw_a = 2'b00; sw_b = 2'b00; sw_op = 3'b000;
        #1;
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_sel", sel, 0);
        check("rst_result", result, 0);
        check("rst_rv", result_valid, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic execute with exact latency
        press_exact(2'b10, 2'b01, 3'b011, 3'b000);
        release_btn();

        // Short glitch never reaches LATCH
        caps0 = n_caps;
        btn_exec = 1'b1; sw_a = 2'b11; sw_b = 2'b11; sw_op = 3'b000;
        repeat (3) @(negedge clk);
        btn_exec = 1'b0;
        check("glitch_debounce_busy", busy, 1);
        repeat (8) @(negedge clk);
        check("glitch_idle", busy, 0);
        check("glitch_rv_kept", result_valid, 1);
        check("glitch_sel_kept", sel, 3'b011);
        check("glitch_no_capture", n_caps, caps0);

        // Long hold with switch activity: one capture, operands frozen
        caps0 = n_caps;
        sw_a = 2'b01; sw_b = 2'b10; sw_op = 3'b100; btn_exec = 1'b1;
        push_exp(2'b01, 2'b10, 3'b100);
        wait_caps(caps0 + 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            sw_a = 2'($urandom); sw_b = 2'($urandom); sw_op = 3'($urandom);
        end
        check("hold_op_a", op_a, 2'b01);
        check("hold_op_b", op_b, 2'b10);
        check("hold_sel", sel, 3'b100);
        check("hold_busy", busy, 1);
        check("hold_one_capture", n_caps, caps0 + 1);
        release_btn();
        check("hold_sel_after", sel, 3'b100);

        // Bounce during RELEASE
        caps0 = n_caps;
        sw_a = 2'b11; sw_b = 2'b10; sw_op = 3'b000; btn_exec = 1'b1;
        push_exp(2'b11, 2'b10, 3'b000);
        wait_caps(caps0 + 1);
        repeat (3) @(negedge clk);
        btn_exec = 1'b0;
        repeat (2) @(negedge clk);
        btn_exec = 1'b1;
        @(negedge clk);
        btn_exec = 1'b0;
        repeat (5) @(negedge clk);
        check("bounce_busy_3low", busy, 1);
        @(negedge clk);
        check("bounce_idle_4low", busy, 0);
        repeat (4) @(negedge clk);

        // Reset during SETTLE
        caps0 = n_caps;
        sw_a = 2'b01; sw_b = 2'b01; sw_op = 3'b001; btn_exec = 1'b1;
        repeat (8) @(negedge clk);
        check("settle_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_op_a", op_a, 0);
        check("midrst_op_b", op_b, 0);
        check("midrst_sel", sel, 0);
        check("midrst_result", result, 0);
        check("midrst_rv", result_valid, 0);
        check("midrst_busy", busy, 0);
        btn_exec = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_capture", n_caps, caps0);
        check("midrst_rv_after", result_valid, 0);
        check("midrst_busy_after", busy, 0);

        // Back-to-back executes with different opcodes
        press_exact(2'b11, 2'b01, 3'b001, 3'b000);
        release_btn();
        press_exact(2'b10, 2'b11, 3'b101, 3'b001);
        release_btn();

        repeat (2) @(negedge clk);
        check("total_captures", n_caps, 5);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
